fifo_uart_tx: RTL

- Serial transmit stage that sits directly downstream of the team's synchronous FIFO.
- Drains bytes from the FIFO's show-ahead read port: data is valid whenever empty is low, and a one-cycle read enable pops it.
- Serialises each byte onto an 8N1-style UART line, LSB first.
- Runs in the single core clock domain; baud timing comes from a clock-divider counter.

---
 rtl/fifo_uart_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// UART 8N1-style transmitter that drains a show-ahead synchronous FIFO, LSB first.
// Optional even parity bit is compiled in with FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3
`ifdef FIFO_UART_TX_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         baud_q, baud_d;
   logic [IW-1:0]         bit_idx_q, bit_idx_d;
   logic                  stop_idx_q, stop_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif
   logic                  baud_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   always_comb begin
      baud_tick  = (baud_q == BAUD_LAST);
      state_d    = state_q;
      baud_d     = baud_tick ? '0 : baud_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d     = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
            // The head word is consumed on the same edge that pops it.
            if (fifo_rd_en) begin
               shift_d = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_d = ^fifo_dout;
`endif
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_tick) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  tx_d      = shift_d[0];
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_tick) begin
               if (stop_idx_q == STOP_LAST) begin
                  stop_idx_d = 1'b0;
                  state_d    = S_IDLE;
                  done_d     = 1'b1;
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      fifo_rd_en = 1'b0;
      busy       = (state_q != S_IDLE);
      tx         = tx_q;
      tx_done    = done_q;
      if (state_q == S_IDLE && !fifo_empty && !rst)
         fifo_rd_en = 1'b1;
   end

endmodule
